// File: rtl/control_unit_mc.sv
// Multicycle control unit for the K&S core: Moore FSM sequencing fetch, decode
// and execute, with RAM wait states, flag-based branches and a retired counter.

package k_and_s_pkg;
  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;
endpackage

module control_unit_mc
  import k_and_s_pkg::*;
#(
  parameter int         MEM_LATENCY = 1,
  parameter int         CNT_W       = 32,
  parameter logic [1:0] MOVE_OP     = 2'b10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        retired_count
);

  typedef enum logic [3:0] {
    FETCH, FETCH_WAIT, REG_INSTR, DECODE, MEM_ADDR, MEM_WAIT,
    LOAD_WB, STORE_WR, ALU_EXEC, ALU_WB, BR_EXEC, HALT
  } state_t;

  localparam bit         HAS_WAIT = (MEM_LATENCY > 0);
  localparam logic [3:0] LAT_FULL = 4'(MEM_LATENCY);
  localparam logic [3:0] LAT_M1   = 4'(MEM_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_nextState;
  decoded_instruction_type r_instr;
  logic [3:0]              r_waitCnt;
  logic [3:0]              w_waitNext;
  logic [CNT_W-1:0]        r_retired;
  logic                    w_retire;
  logic                    w_taken;
  logic                    w_isMove;
  logic [1:0]              w_aluOp;
  logic                    w_unusedFlag;

  assign w_unusedFlag  = unsigned_overflow;
  assign retired_count = r_retired;
  assign w_isMove      = (r_instr == I_MOVE);

  always_comb begin
    w_aluOp = MOVE_OP;
    case (r_instr)
      I_ADD:   w_aluOp = 2'b00;
      I_SUB:   w_aluOp = 2'b01;
      I_AND:   w_aluOp = 2'b10;
      I_OR:    w_aluOp = 2'b11;
      default: w_aluOp = MOVE_OP;
    endcase
  end

  // Branch condition uses the flag inputs live during BR_EXEC.
  always_comb begin
    w_taken = 1'b0;
    case (r_instr)
      I_BRANCH: w_taken = 1'b1;
      I_BZERO:  w_taken = zero_op;
      I_BNZERO: w_taken = ~zero_op;
      I_BNEG:   w_taken = neg_op;
      I_BNNEG:  w_taken = ~neg_op;
      I_BOV:    w_taken = signed_overflow;
      I_BNOV:   w_taken = ~signed_overflow;
      default:  w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_nextState      = r_state;
    w_waitNext       = r_waitCnt;
    w_retire         = 1'b0;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (r_state)
      FETCH: begin
        if (HAS_WAIT) begin
          w_nextState = FETCH_WAIT;
          w_waitNext  = LAT_M1;
        end else begin
          w_nextState = REG_INSTR;
        end
      end
      FETCH_WAIT: begin
        if (r_waitCnt == 4'd0) w_nextState = REG_INSTR;
        else                   w_waitNext  = r_waitCnt - 4'd1;
      end
      REG_INSTR: begin
        ir_enable   = 1'b1;
        pc_enable   = 1'b1;
        w_nextState = DECODE;
      end
      DECODE: begin
        case (decoded_instruction)
          I_LOAD, I_STORE:                    w_nextState = MEM_ADDR;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR:  w_nextState = ALU_EXEC;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:             w_nextState = BR_EXEC;
          I_HALT: begin
            w_nextState = HALT;
            w_retire    = 1'b1;
          end
          default: begin
            w_nextState = FETCH;
            w_retire    = 1'b1;
          end
        endcase
      end
      // Loads always spend one turnaround cycle in MEM_WAIT after the operand
      // address settles, then MEM_LATENCY more before read data is valid.
      MEM_ADDR: begin
        addr_sel = 1'b1;
        if (r_instr == I_STORE) begin
          w_nextState = STORE_WR;
        end else begin
          w_nextState = MEM_WAIT;
          w_waitNext  = LAT_FULL;
        end
      end
      MEM_WAIT: begin
        addr_sel = 1'b1;
        if (r_waitCnt == 4'd0) w_nextState = LOAD_WB;
        else                   w_waitNext  = r_waitCnt - 4'd1;
      end
      LOAD_WB: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        w_nextState      = FETCH;
        w_retire         = 1'b1;
      end
      STORE_WR: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        w_nextState      = FETCH;
        w_retire         = 1'b1;
      end
      ALU_EXEC: begin
        operation        = w_aluOp;
        flags_reg_enable = ~w_isMove;
        w_nextState      = ALU_WB;
      end
      ALU_WB: begin
        operation        = w_aluOp;
        flags_reg_enable = ~w_isMove;
        write_reg_enable = 1'b1;
        w_nextState      = FETCH;
        w_retire         = 1'b1;
      end
      BR_EXEC: begin
        branch      = w_taken;
        pc_enable   = w_taken;
        w_nextState = FETCH;
        w_retire    = 1'b1;
      end
      HALT: begin
        halt = 1'b1;
      end
      default: w_nextState = FETCH;
    endcase
  end

  // The instruction class is latched on leaving DECODE and held until the next fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_waitCnt <= 4'd0;
      r_instr   <= I_NOP;
      r_retired <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_waitNext;
      if (r_state == DECODE) r_instr <= decoded_instruction;
      if (w_retire && (r_retired != {CNT_W{1'b1}})) r_retired <= r_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: four instances (L=0, L=1, L=3, 3-bit counter)
// share stimulus; each test follows one instance cycle by cycle.

module tb_control_unit_mc;
  import k_and_s_pkg::*;

  // Packed output view: {branch, pc_en, ir_en, wr_reg, addr_sel, c_sel, op[1:0], flags_en, ram_we, halt}
  localparam logic [10:0] V_NONE = 11'h000;
  localparam logic [10:0] V_REGI = 11'h300;
  localparam logic [10:0] V_ADDR = 11'h040;
  localparam logic [10:0] V_LDWB = 11'h0E0;
  localparam logic [10:0] V_STWR = 11'h042;
  localparam logic [10:0] V_BRT  = 11'h600;
  localparam logic [10:0] V_HALT = 11'h001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decoded_instruction_type decodedInstruction = I_ADD;
  logic zeroOp = 1'b0;
  logic negOp = 1'b0;
  logic unsignedOv = 1'b0;
  logic signedOv = 1'b0;

  wire [10:0] out0, out1, out3, outS;
  wire [31:0] cnt0, cnt1, cnt3;
  wire [2:0]  cntS;

  int totalChecks = 0;
  int badChecks = 0;
  logic [10:0] expQ[$];

  always #5 clk = ~clk;

  control_unit_mc #(.MEM_LATENCY(0), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .decoded_instruction(decodedInstruction),
    .zero_op(zeroOp), .neg_op(negOp), .unsigned_overflow(unsignedOv), .signed_overflow(signedOv),
    .branch(out0[10]), .pc_enable(out0[9]), .ir_enable(out0[8]), .write_reg_enable(out0[7]),
    .addr_sel(out0[6]), .c_sel(out0[5]), .operation(out0[4:3]), .flags_reg_enable(out0[2]),
    .ram_write_enable(out0[1]), .halt(out0[0]), .retired_count(cnt0));

  control_unit_mc #(.MEM_LATENCY(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .decoded_instruction(decodedInstruction),
    .zero_op(zeroOp), .neg_op(negOp), .unsigned_overflow(unsignedOv), .signed_overflow(signedOv),
    .branch(out1[10]), .pc_enable(out1[9]), .ir_enable(out1[8]), .write_reg_enable(out1[7]),
    .addr_sel(out1[6]), .c_sel(out1[5]), .operation(out1[4:3]), .flags_reg_enable(out1[2]),
    .ram_write_enable(out1[1]), .halt(out1[0]), .retired_count(cnt1));

  control_unit_mc #(.MEM_LATENCY(3), .CNT_W(32)) u3 (
    .clk(clk), .rst(rst), .decoded_instruction(decodedInstruction),
    .zero_op(zeroOp), .neg_op(negOp), .unsigned_overflow(unsignedOv), .signed_overflow(signedOv),
    .branch(out3[10]), .pc_enable(out3[9]), .ir_enable(out3[8]), .write_reg_enable(out3[7]),
    .addr_sel(out3[6]), .c_sel(out3[5]), .operation(out3[4:3]), .flags_reg_enable(out3[2]),
    .ram_write_enable(out3[1]), .halt(out3[0]), .retired_count(cnt3));

  control_unit_mc #(.MEM_LATENCY(0), .CNT_W(3)) uS (
    .clk(clk), .rst(rst), .decoded_instruction(decodedInstruction),
    .zero_op(zeroOp), .neg_op(negOp), .unsigned_overflow(unsignedOv), .signed_overflow(signedOv),
    .branch(outS[10]), .pc_enable(outS[9]), .ir_enable(outS[8]), .write_reg_enable(outS[7]),
    .addr_sel(outS[6]), .c_sel(outS[5]), .operation(outS[4:3]), .flags_reg_enable(outS[2]),
    .ram_write_enable(outS[1]), .halt(outS[0]), .retired_count(cntS));

  function automatic logic [10:0] getOut(input int sel);
    case (sel)
      0:       getOut = out0;
      1:       getOut = out1;
      3:       getOut = out3;
      default: getOut = outS;
    endcase
  endfunction

  function automatic logic [63:0] getCnt(input int sel);
    case (sel)
      0:       getCnt = 64'(cnt0);
      1:       getCnt = 64'(cnt1);
      3:       getCnt = 64'(cnt3);
      default: getCnt = 64'(cntS);
    endcase
  endfunction

  function automatic logic [10:0] aluVec(input logic [1:0] op, input bit fl, input bit wb);
    aluVec = {3'b000, wb, 2'b00, op, fl, 2'b00};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // FETCH, lat wait cycles, REG_INSTR, DECODE
  task automatic buildFront(input int lat);
    expQ.delete();
    expQ.push_back(V_NONE);
    repeat (lat) expQ.push_back(V_NONE);
    expQ.push_back(V_REGI);
    expQ.push_back(V_NONE);
  endtask

  // Walks one instruction from its FETCH cycle; the input is scrambled once decode is past.
  task automatic applyStimulus(input string tag, input int sel, input int lat,
                               input decoded_instruction_type instr,
                               input int cntBefore, input int cntAfter);
    decodedInstruction = instr;
    for (int i = 0; i < expQ.size(); i++) begin
      checkOutput($sformatf("%s.out%0d", tag, i), 64'(getOut(sel)), 64'(expQ[i]));
      checkOutput($sformatf("%s.cnt%0d", tag, i), getCnt(sel), 64'(cntBefore));
      if (i > lat + 2) decodedInstruction = I_HALT;
      @(negedge clk);
    end
    checkOutput($sformatf("%s.retired", tag), getCnt(sel), 64'(cntAfter));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    decoded_instruction_type aluList[5] = '{I_ADD, I_SUB, I_AND, I_OR, I_MOVE};
    logic [1:0] aluOps[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    decoded_instruction_type brList[9] = '{I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BRANCH,
                                          I_BOV, I_BNOV, I_BOV, I_BNOV};
    bit brSov[9]   = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    bit brTaken[9] = '{1, 0, 0, 1, 1, 0, 1, 1, 0};
    decoded_instruction_type toggleList[4] = '{I_ADD, I_LOAD, I_NOP, I_STORE};
    decoded_instruction_type instr;
    int expCnt;

    // Reset with L=1 while an ADD sits on the decoder output.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rstOut%0d", i), 64'(out1), 64'(V_NONE));
      checkOutput($sformatf("rstCnt%0d", i), 64'(cnt1), 64'd0);
    end
    rst = 1'b0;
    buildFront(1);
    expQ.push_back(aluVec(2'b00, 1'b1, 1'b0));
    expQ.push_back(aluVec(2'b00, 1'b1, 1'b1));
    applyStimulus("rstAdd", 1, 1, I_ADD, 0, 1);

    // ALU sequence, L=0.
    applyReset(2);
    for (int i = 0; i < 5; i++) begin
      buildFront(0);
      expQ.push_back(aluVec(aluOps[i], i < 4, 1'b0));
      expQ.push_back(aluVec(aluOps[i], i < 4, 1'b1));
      applyStimulus($sformatf("alu%0d", i), 0, 0, aluList[i], i, i + 1);
    end

    // Memory, L=3: load 12 cycles, store 8 cycles.
    applyReset(2);
    buildFront(3);
    expQ.push_back(V_ADDR);
    repeat (4) expQ.push_back(V_ADDR);
    expQ.push_back(V_LDWB);
    applyStimulus("load3", 3, 3, I_LOAD, 0, 1);
    buildFront(3);
    expQ.push_back(V_ADDR);
    expQ.push_back(V_STWR);
    applyStimulus("store3", 3, 3, I_STORE, 1, 2);

    // Memory, L=0: load 6 cycles, store 5 cycles.
    applyReset(2);
    buildFront(0);
    expQ.push_back(V_ADDR);
    expQ.push_back(V_ADDR);
    expQ.push_back(V_LDWB);
    applyStimulus("load0", 0, 0, I_LOAD, 0, 1);
    buildFront(0);
    expQ.push_back(V_ADDR);
    expQ.push_back(V_STWR);
    applyStimulus("store0", 0, 0, I_STORE, 1, 2);

    // Branches, L=0, zero_op=1, neg_op=0.
    applyReset(2);
    zeroOp = 1'b1;
    negOp = 1'b0;
    unsignedOv = 1'b1;
    for (int i = 0; i < 9; i++) begin
      signedOv = brSov[i];
      buildFront(0);
      expQ.push_back(brTaken[i] ? V_BRT : V_NONE);
      applyStimulus($sformatf("br%0d", i), 0, 0, brList[i], i, i + 1);
    end
    signedOv = 1'b0;
    unsignedOv = 1'b0;

    // Reset mid-store: no strobe follows.
    applyReset(2);
    decodedInstruction = I_STORE;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abortAddr", 64'(out0), 64'(V_ADDR));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortRst", 64'(out0), 64'(V_NONE));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abortAfter", 64'(out0), 64'(V_REGI));

    // HALT is sticky and retires once.
    applyReset(2);
    buildFront(0);
    applyStimulus("haltEntry", 0, 0, I_HALT, 0, 1);
    for (int i = 0; i < 20; i++) begin
      decodedInstruction = toggleList[i % 4];
      checkOutput($sformatf("halt%0d", i), 64'(out0), 64'(V_HALT));
      checkOutput($sformatf("haltCnt%0d", i), 64'(cnt0), 64'd1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("haltRstOut", 64'(out0), 64'(V_NONE));
    checkOutput("haltRstCnt", 64'(cnt0), 64'd0);
    rst = 1'b0;
    buildFront(0);
    applyStimulus("resume", 0, 0, I_NOP, 0, 1);

    // Saturation on the 3-bit counter; one illegal decode acts as NOP.
    applyReset(2);
    for (int i = 0; i < 10; i++) begin
      instr = (i == 5) ? decoded_instruction_type'(5'd27) : I_NOP;
      expCnt = (i + 1 > 7) ? 7 : i + 1;
      buildFront(0);
      applyStimulus($sformatf("sat%0d", i), 4, 0, instr, (i > 7) ? 7 : i, expCnt);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
